// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, bit-period helpers, 8N1 frame constants.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        STOP_LEVEL = 1'b1;
    localparam logic        IDLE_LEVEL = 1'b1;

    function automatic int unsigned calc_div_val(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int unsigned calc_half_val(input int unsigned clk_freq,
                                                  input int unsigned baud_rate);
        return calc_div_val(clk_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value is parameterised.
module uart_sync #(
    parameter logic reset_val = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= reset_val;
            q    <= reset_val;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with start-bit glitch rejection and framing-error detection.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting on every bit decision.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned clk_freq  = 100000000,
    parameter int unsigned baud_rate = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned DIV_VAL   = calc_div_val(clk_freq, baud_rate);
    localparam int unsigned HALF_VAL  = calc_half_val(clk_freq, baud_rate);
    localparam logic [15:0] DIV_LAST  = 16'(DIV_VAL - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_VAL - 1);
    localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

    uart_state_t state, state_next;
    logic [15:0] baud_cnt, baud_next;
    logic [2:0]  bit_cnt, bit_next;
    logic [7:0]  shreg, shreg_next;
    logic [7:0]  data_next;
    logic        valid_next, err_next;
    logic        rxd_s;
    logic        line;

    uart_sync #(.reset_val(IDLE_LEVEL)) rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rxd_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // Decision counts are consecutive cycles, so a 2-deep history holds the T-2 and T-1 samples.
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (reset) hist <= '1;
        else       hist <= {hist[0], rxd_s};
    end

    assign line = (rxd_s & hist[0]) | (rxd_s & hist[1]) | (hist[0] & hist[1]);
`else
    assign line = rxd_s;
`endif

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        data_next  = data;
        valid_next = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (rxd_s != IDLE_LEVEL) begin
                    state_next = START;
                    baud_next  = '0;
                end
            end
            START: begin
                if (baud_cnt == HALF_LAST) begin
                    if (line == IDLE_LEVEL) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        baud_next  = '0;
                        bit_next   = '0;
                    end
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (baud_cnt == DIV_LAST) begin
                    baud_next  = '0;
                    shreg_next = {line, shreg[7:1]};
                    if (bit_cnt == BIT_LAST) state_next = STOP;
                    else                     bit_next   = bit_cnt + 3'd1;
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so an immediately following start edge is not missed.
                if (baud_cnt == DIV_LAST) begin
                    state_next = IDLE;
                    baud_next  = '0;
                    if (line == STOP_LEVEL) begin
                        data_next  = shreg;
                        valid_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_cnt   <= bit_next;
            shreg     <= shreg_next;
            data      <= data_next;
            valid     <= valid_next;
            frame_err <= err_next;
            busy      <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at div_val=16, half_val=8; honours UART_RX_MAJORITY_EN.
module tb_uart_receiver;

    localparam int DIV  = 16;
    localparam int HALF = 8;
    // rxd edge to pulse cycle: 2 sync + half_val + 9 bit periods + 1 register stage.
    localparam int LAT  = 2 + HALF + 9 * DIV + 1;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rxd   = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         at;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] prev_byte = 8'h00;

    uart_receiver #(.clk_freq(1600), .baud_rate(100)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && (valid === 1'b1 || frame_err === 1'b1)) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: valid=%b frame_err=%b data=0x%02h at cycle %0d, expected none",
                         valid, frame_err, data, cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", {30'd0, valid, frame_err}, e.err ? 32'd1 : 32'd2);
                check("pulse_data", {24'd0, data}, {24'd0, e.data});
                check("pulse_cycle", cyc, e.at);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cycle(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    // Drives one frame starting in the current cycle; reset_at >= 0 aborts with reset at that offset.
    task automatic send_frame(input logic [7:0] d, input logic [7:0] expect_data, input logic stop,
                              input logic glitch, input int reset_at);
        int         n = cyc;
        logic [9:0] bits;
        logic       aborted = 1'b0;
        bits = {stop, d, 1'b0};
        if (reset_at < 0) begin
            sb.push_back('{data: stop ? expect_data : prev_byte, err: !stop, at: n + LAT});
            if (stop) prev_byte = expect_data;
        end
        for (int i = 0; i < 10 && !aborted; i++) begin
            for (int j = 0; j < DIV && !aborted; j++) begin
                if (i * DIV + j == reset_at) begin
                    reset = 1'b1;
                    rxd   = 1'b1;
                    @(posedge clk);
                    #1;
                    reset     = 1'b0;
                    prev_byte = 8'h00;
                    aborted   = 1'b1;
                    check("rst_mid_data", {24'd0, data}, 32'h00);
                    check("rst_mid_valid", {31'd0, valid}, 32'd0);
                    check("rst_mid_frame_err", {31'd0, frame_err}, 32'd0);
                    check("rst_mid_busy", {31'd0, busy}, 32'd0);
                end else begin
                    rxd = (glitch && i >= 1 && i <= 8 && j == HALF) ? ~bits[i] : bits[i];
                    @(posedge clk);
                    #1;
                end
            end
        end
        rxd = 1'b1;
    endtask

    initial begin
        int         n;
        logic [7:0] glitch_exp;
`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'h5A;
`else
        glitch_exp = 8'hA5;
`endif
        idle(3);
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        idle(5);

        n = cyc;
        fork
            send_frame(8'hA5, 8'hA5, 1'b1, 1'b0, -1);
            begin
                wait_cycle(n + 2);
                check("busy_before_t0", {31'd0, busy}, 32'd0);
                wait_cycle(n + 3);
                check("busy_after_t0", {31'd0, busy}, 32'd1);
                wait_cycle(n + LAT - 1);
                check("busy_at_stop", {31'd0, busy}, 32'd1);
                wait_cycle(n + LAT);
                check("busy_drop", {31'd0, busy}, 32'd0);
            end
        join
        idle(20);

        n   = cyc;
        rxd = 1'b0;
        idle(5);
        rxd = 1'b1;
        wait_cycle(n + 2 + HALF);
        check("false_start_busy", {31'd0, busy}, 32'd1);
        wait_cycle(n + 3 + HALF);
        check("false_start_idle", {31'd0, busy}, 32'd0);
        idle(20);

        send_frame(8'h3C, 8'h3C, 1'b0, 1'b0, -1);
        idle(30);

        send_frame(8'h00, 8'h00, 1'b1, 1'b0, -1);
        send_frame(8'hFF, 8'hFF, 1'b1, 1'b0, -1);
        send_frame(8'h55, 8'h55, 1'b1, 1'b0, -1);
        idle(30);

        send_frame(8'hC3, 8'hC3, 1'b1, 1'b0, 5 * DIV + HALF);
        idle(20);
        send_frame(8'h81, 8'h81, 1'b1, 1'b0, -1);
        idle(30);

        send_frame(8'h5A, glitch_exp, 1'b1, 1'b1, -1);
        idle(40);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Asynchronous serial receiver for the UART datapath: the sink end of the serial line driven by the team's UART transmitter. It recovers 8N1 frames (one start bit, 8 data bits LSB-first, one stop bit) from `rxd` and presents each byte as a one-cycle `valid` pulse. Framing errors are flagged and false start bits are rejected. It shares the transmitter's `clk_freq`/`baud_rate` parameterisation so both ends compute an identical bit period.

## Interface
- `clk_freq`, default 100000000, system clock frequency in Hz.
- `baud_rate`, default 9600, line rate in bits/s.
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `rxd`  input  1  serial line, asynchronous to `clk`, idles high.
- `data`  output  8  last received byte; holds until the next frame completes.
- `valid`  output  1  one-cycle pulse: `data` holds a byte with a good stop bit.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `busy`  output  1  high while a frame is in progress.

## Operation
- `div_val = clk_freq / baud_rate` (integer division); `half_val = div_val / 2`.
- `div_val` must be ≤ 65535 and ≥ 4.
- Baud counter is 16 bits wide; bit counter is 3 bits wide.
- `rxd` passes through a 2-FF synchronizer (reset value 1) to give `rxd_s`; all decisions use `rxd_s` only.
- State machine: IDLE, START, DATA, STOP.
  - IDLE: when `rxd_s`==0, go to START with `baud_cnt`=0. Otherwise stay.
  - START: when `baud_cnt`==`half_val`-1, sample the line.
    - Sample 0: go to DATA with `baud_cnt`=0 and `bit_cnt`=0.
    - Sample 1: glitch; return to IDLE with no output.
    - Otherwise increment `baud_cnt`.
  - DATA: when `baud_cnt`==`div_val`-1, sample the line and set `baud_cnt` to 0.
    - Shift the sample into the MSB of the 8-bit shift register, shifting right, so bits arrive LSB-first.
    - If `bit_cnt`==7, go to STOP; else increment `bit_cnt`.
  - STOP: when `baud_cnt`==`div_val`-1, sample the line.
    - Sample 1: load `data` from the shift register and pulse `valid`.
    - Sample 0: pulse `frame_err`; `data` is unchanged.
    - Either way, go to IDLE. This happens at mid-stop-bit, so a start edge immediately after the stop bit is caught.
- `busy` = (state != IDLE), registered.
- Simultaneous events: `valid` and `frame_err` are never high in the same cycle.
- A line held low continuously re-arms from IDLE and yields repeated `frame_err` pulses with 0x00 data, never `valid`.
- Reset mid-frame: the partial frame is discarded and no pulse is emitted.
- Reset values: `data`=0x00, `valid`=0, `frame_err`=0, `busy`=0, state=IDLE, both counters 0, shift register 0, synchronizer flops 1.

## Timing
- `rxd_s` lags `rxd` by 2 cycles.
- Let t0 be the first cycle IDLE sees `rxd_s`==0. The START check occurs at cycle t0+`half_val`, and data bit k (k=0..7) is sampled at t0+`half_val`+(k+1)·`div_val`.
- Stop sample at t0+`half_val`+9·`div_val`. `valid` or `frame_err` is high in the following cycle only, and `busy` drops in that same cycle.
- Back-to-back frames at exactly `baud_rate` are received without loss.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each START, DATA and STOP decision is the 2-of-3 majority of `rxd_s` sampled at `baud_cnt`==T-2, T-1 and T, where T is that state's decision count.
  - The decision is still taken at T, so the cycle timing above is unchanged.
- Not defined: the single sample at T is used. The majority logic and its sample register are absent.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP);
  - functions computing `div_val` and `half_val` from the two parameters;
  - frame-format constants: data bits = 8, stop level = 1, idle level = 1.
- The transmitter uses the same package.
- One sub-module, `uart_sync`: a 2-FF synchronizer with parameterised reset value, reused for any asynchronous input.

## Test plan
Test parameters: `clk_freq`=1600, `baud_rate`=100 (`div_val`=16, `half_val`=8) unless noted.
- Frame 0xA5 with a good stop bit -> exactly one `valid` pulse at t0+8+144+1, `data`=0xA5, `frame_err` stays 0, `busy` high for the frame duration.
- `rxd` low for 5 cycles, then high -> no `valid`, no `frame_err`, `busy` returns to 0 about 8 cycles after going high.
- Frame 0x3C with the stop bit driven 0 -> one `frame_err` pulse, no `valid`, `data` keeps its previous value.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three `valid` pulses in order with the matching bytes.
- `reset` asserted mid-way through data bit 4 of 0xC3 -> all outputs at reset values next cycle, no pulse. The following frame 0x81 is received correctly.
- Under `UART_RX_MAJORITY_EN`: frame 0x5A with a 1-cycle inverted glitch at `baud_cnt`==T on each bit -> `data`=0x5A and `valid`. Without the macro the same stimulus yields a corrupted byte.
